// File: rtl/iob_reg_pipe_if.sv
// Handshake bundle for iob_reg_pipe: upstream valid/ready/data in, downstream valid/ready/data out.
// slave = the pipe itself, master = the environment driving and draining it.
interface iob_reg_pipe_if #(
    parameter int unsigned DATA_W = 32
);
    logic              iob_valid_i;
    logic              iob_ready_o;
    logic [DATA_W-1:0] data_i;
    logic              iob_valid_o;
    logic              iob_ready_i;
    logic [DATA_W-1:0] data_o;

    modport slave (
        input  iob_valid_i,
        input  data_i,
        input  iob_ready_i,
        output iob_ready_o,
        output iob_valid_o,
        output data_o
    );

    modport master (
        output iob_valid_i,
        output data_i,
        output iob_ready_i,
        input  iob_ready_o,
        input  iob_valid_o,
        input  data_o
    );
endinterface

// File: rtl/iob_reg_pipe.sv
// Elastic DEPTH-stage valid/ready pipeline register with bubble collapse.
// Optional stored-word counter level_o is enabled by defining IOB_REG_PIPE_LEVEL_EN.
module iob_reg_pipe #(
    parameter int unsigned       DATA_W  = 32,
    parameter int unsigned       DEPTH   = 2,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    input  logic                       clear_i,
    iob_reg_pipe_if.slave              bus
`ifdef IOB_REG_PIPE_LEVEL_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] level_o
`endif
);

    logic [DEPTH-1:0]  r_valid;
    logic [DATA_W-1:0] r_data [DEPTH];

    logic [DEPTH-1:0]  w_adv;
    logic [DEPTH-1:0]  w_vin;
    logic [DATA_W-1:0] w_din [DEPTH];
    logic              w_push;

    // The recursive advance chain is flattened: stage k may advance when any
    // stage from k to the output is empty, or the output is being drained.
    always_comb begin
        w_adv = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            w_adv[k] = bus.iob_ready_i | (|(~r_valid >> k));
        end
    end

    assign bus.iob_ready_o = w_adv[0] & en_i & ~clear_i & ~rst_i;
    assign bus.iob_valid_o = r_valid[DEPTH-1] & en_i;
    assign bus.data_o      = r_data[DEPTH-1];
    assign w_push          = bus.iob_valid_i & bus.iob_ready_o;

    always_comb begin
        w_vin    = '0;
        w_vin[0] = w_push;
        w_din[0] = bus.data_i;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            w_vin[k] = r_valid[k-1];
            w_din[k] = r_data[k-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_valid <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                r_data[k] <= RST_VAL;
            end
        end else if (en_i) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (w_adv[k]) begin
                    r_valid[k] <= w_vin[k];
                    if (w_vin[k]) begin
                        r_data[k] <= w_din[k];
                    end
                end
            end
        end
    end

`ifdef IOB_REG_PIPE_LEVEL_EN
    localparam int unsigned LVL_W = $clog2(DEPTH+1);

    logic [LVL_W-1:0] r_level;
    logic             w_pop;

    assign w_pop   = bus.iob_valid_o & bus.iob_ready_i;
    assign level_o = r_level;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_level <= '0;
        end else if (w_push && !w_pop) begin
            r_level <= r_level + LVL_W'(1);
        end else if (w_pop && !w_push) begin
            r_level <= r_level - LVL_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_iob_reg_pipe.sv
// Directed-vector bench for iob_reg_pipe: DEPTH=3 table plus a DEPTH=1 toggling-ready stream.
module tb_iob_reg_pipe;

    logic clk;
    logic rst;
    logic en;
    logic clr;

    iob_reg_pipe_if #(.DATA_W(8)) if3 ();
    iob_reg_pipe_if #(.DATA_W(8)) if1 ();

`ifdef IOB_REG_PIPE_LEVEL_EN
    logic [1:0] lvl3;
    logic [0:0] lvl1;
`endif

    iob_reg_pipe #(.DATA_W(8), .DEPTH(3), .RST_VAL(8'hA5)) u_dut3 (
        .clk_i   (clk),
        .rst_i   (rst),
        .en_i    (en),
        .clear_i (clr),
        .bus     (if3.slave)
`ifdef IOB_REG_PIPE_LEVEL_EN
        ,
        .level_o (lvl3)
`endif
    );

    iob_reg_pipe #(.DATA_W(8), .DEPTH(1), .RST_VAL(8'h00)) u_dut1 (
        .clk_i   (clk),
        .rst_i   (rst),
        .en_i    (en),
        .clear_i (clr),
        .bus     (if1.slave)
`ifdef IOB_REG_PIPE_LEVEL_EN
        ,
        .level_o (lvl1)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst;
        logic       en;
        logic       clr;
        logic       vin;
        logic [7:0] din;
        logic       rdy;
        logic       vout;
        logic       rdyo;
        logic [7:0] dout;
        logic [1:0] lvl;
        logic       all;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] got %h expected %h", nm, idx, got, exp);
        end
    endtask

    initial begin
        logic       m_full;
        logic       exp_rdy;
        logic       pop;
        logic       push;
        logic [7:0] q[$];
        logic [7:0] exp_w;
        int         sent;
        int         rcvd;

        // rst en clr vin din rdy | vout rdyo dout lvl all
        tbl.push_back(vec_t'{1,1,0,1,8'h00,0, 0,0,8'hA5,0, 0});
        tbl.push_back(vec_t'{1,1,0,1,8'h77,0, 0,0,8'hA5,0, 1});
        tbl.push_back(vec_t'{0,1,0,1,8'h11,1, 0,1,8'hA5,0, 1});
        tbl.push_back(vec_t'{0,1,0,1,8'h22,1, 0,1,8'hA5,1, 1});
        tbl.push_back(vec_t'{0,1,0,1,8'h33,1, 0,1,8'hA5,2, 1});
        tbl.push_back(vec_t'{0,1,0,0,8'h00,1, 1,1,8'h11,3, 1});
        tbl.push_back(vec_t'{0,1,0,0,8'h00,1, 1,1,8'h22,2, 1});
        tbl.push_back(vec_t'{0,1,0,0,8'h00,1, 1,1,8'h33,1, 1});
        tbl.push_back(vec_t'{0,1,0,1,8'h41,0, 0,1,8'h33,0, 1});
        tbl.push_back(vec_t'{0,1,0,1,8'h42,0, 0,1,8'h33,1, 1});
        tbl.push_back(vec_t'{0,1,0,1,8'h43,0, 0,1,8'h33,2, 1});
        tbl.push_back(vec_t'{0,1,0,1,8'h44,0, 1,0,8'h41,3, 1});
        tbl.push_back(vec_t'{0,1,0,1,8'h44,0, 1,0,8'h41,3, 1});
        tbl.push_back(vec_t'{0,1,0,1,8'h44,1, 1,1,8'h41,3, 1});
        tbl.push_back(vec_t'{0,1,0,1,8'h45,1, 1,1,8'h42,3, 1});
        tbl.push_back(vec_t'{0,1,0,0,8'h00,1, 1,1,8'h43,3, 1});
        tbl.push_back(vec_t'{0,1,0,0,8'h00,1, 1,1,8'h44,2, 1});
        tbl.push_back(vec_t'{0,1,0,0,8'h00,1, 1,1,8'h45,1, 1});
        tbl.push_back(vec_t'{0,1,0,1,8'hAA,0, 0,1,8'h45,0, 1});
        tbl.push_back(vec_t'{0,1,0,0,8'h00,0, 0,1,8'h45,1, 1});
        tbl.push_back(vec_t'{0,1,0,0,8'h00,0, 0,1,8'h45,1, 1});
        tbl.push_back(vec_t'{0,1,0,1,8'hBB,0, 1,1,8'hAA,1, 1});
        tbl.push_back(vec_t'{0,1,0,0,8'h00,0, 1,1,8'hAA,2, 1});
        tbl.push_back(vec_t'{0,1,0,0,8'h00,0, 1,1,8'hAA,2, 1});
        for (int i = 0; i < 4; i++) begin
            tbl.push_back(vec_t'{0,0,0,1,8'hCC,1, 0,0,8'hAA,2, 1});
        end
        tbl.push_back(vec_t'{0,1,0,1,8'hCC,1, 1,1,8'hAA,2, 1});
        tbl.push_back(vec_t'{0,1,1,1,8'hDD,0, 1,0,8'hBB,2, 1});
        tbl.push_back(vec_t'{0,1,0,0,8'h00,1, 0,1,8'hA5,0, 1});
        tbl.push_back(vec_t'{0,1,0,0,8'h00,1, 0,1,8'hA5,0, 1});

        if1.iob_valid_i = 1'b0;
        if1.data_i      = 8'h00;
        if1.iob_ready_i = 1'b0;

        foreach (tbl[i]) begin
            rst             = tbl[i].rst;
            en              = tbl[i].en;
            clr             = tbl[i].clr;
            if3.iob_valid_i = tbl[i].vin;
            if3.data_i      = tbl[i].din;
            if3.iob_ready_i = tbl[i].rdy;
            #1;
            chk("d3_ready_o", i, 32'(if3.iob_ready_o), 32'(tbl[i].rdyo));
            if (tbl[i].all) begin
                chk("d3_valid_o", i, 32'(if3.iob_valid_o), 32'(tbl[i].vout));
                chk("d3_data_o", i, 32'(if3.data_o), 32'(tbl[i].dout));
`ifdef IOB_REG_PIPE_LEVEL_EN
                chk("d3_level_o", i, 32'(lvl3), 32'(tbl[i].lvl));
`endif
            end
            @(posedge clk);
            #1;
        end

        // DEPTH=1: ready toggles every cycle, random valid, 100 words through a scoreboard
        if3.iob_valid_i = 1'b0;
        if3.iob_ready_i = 1'b1;
        rst = 1'b1;
        en  = 1'b1;
        clr = 1'b0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        m_full = 1'b0;
        sent   = 0;
        rcvd   = 0;
        if1.iob_ready_i = 1'b0;
        for (int cyc = 0; cyc < 2000 && (sent < 100 || m_full); cyc++) begin
            if1.iob_ready_i = ~if1.iob_ready_i;
            if1.iob_valid_i = (sent < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
            if1.data_i      = 8'($urandom_range(0, 255));
            #1;
            exp_rdy = ~m_full | if1.iob_ready_i;
            chk("d1_ready_o", cyc, 32'(if1.iob_ready_o), 32'(exp_rdy));
            chk("d1_valid_o", cyc, 32'(if1.iob_valid_o), 32'(m_full));
            pop  = m_full & if1.iob_ready_i;
            push = if1.iob_valid_i & exp_rdy;
            if (pop) begin
                exp_w = q.pop_front();
                chk("d1_data_o", rcvd, 32'(if1.data_o), 32'(exp_w));
                rcvd++;
            end
            if (push) begin
                q.push_back(if1.data_i);
                sent++;
            end
            m_full = (m_full & ~pop) | push;
            @(posedge clk);
            #1;
        end
        if1.iob_valid_i = 1'b0;
        #1;
        chk("d1_sent", 0, 32'(sent), 32'd100);
        chk("d1_rcvd", 0, 32'(rcvd), 32'd100);
        chk("d1_empty", 0, 32'(if1.iob_valid_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
